fsm_step_ctrl: RTL
==================

# fsm_step_ctrl

Front-end control stage for the sequence FSM. It conditions three raw push-button inputs: two-flop synchronizer, debouncer and rising-edge detector per button. From them it generates the `enable` and `up_down` signals that drive the FSM's `enable`/`up_down` inputs. It supports three modes:
- free-running, with one `enable` pulse every `PRESC` cycles;
- single-step;
- stopped.

## Interface
Parameters:
- `DEB_CYCLES`, default 4: consecutive stable synchronized samples required before a button level is accepted; must be ≥ 2.
- `PRESC`, default 5: period in clock cycles of `enable` pulses in RUN mode; must be ≥ 2.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `btn_run`  in  1  raw, asynchronous run/stop button, active-high.
- `btn_step`  in  1  raw, asynchronous single-step button, active-high.
- `btn_dir`  in  1  raw, asynchronous direction-toggle button, active-high.
- `enable`  out  1  one-cycle advance strobe to the sequence FSM.
- `up_down`  out  1  direction: 1 = up, 0 = down.
- `run_led`  out  1  high while in RUN mode.

## Operation
Button conditioning (identical for each button):
- Synchronizer: 2 flops; `s` is the second-flop output.
- Debouncer: counter increments while `s` ≠ `deb` and clears when they are equal. When `s` ≠ `deb` and the counter equals `DEB_CYCLES`−1, then `deb` ← `s` and the counter ← 0.
- A press is the cycle in which `deb` rises, detected as `deb` & ~`deb_q`. Falling edges generate nothing.

Mode FSM states: STOP, RUN, STEP. Reset state is STOP.
- STOP:
  - run press → RUN, and the prescaler clears to 0.
  - step press (no run press) → STEP.
- STEP: unconditional → STOP after one cycle.
- RUN:
  - run press → STOP.
  - step presses are ignored.
- Simultaneous run and step press in STOP: run wins; the step press is discarded.

Prescaler:
- Counts 0..`PRESC`−1 while in RUN and wraps to 0.
- Held at 0 outside RUN.

Outputs (all Moore, from registered state):
- `enable` = (state==STEP) | (state==RUN & cnt==`PRESC`−1).
- `run_led` = (state==RUN).
- `up_down`:
  - register, reset value 1;
  - toggles on every dir press, in any mode;
  - a dir press coinciding with a run or step press is still honoured.

Reset:
- `rst` high at any time, including mid-RUN or mid-STEP, returns everything at the next edge:
  - state = STOP, cnt = 0;
  - all debouncers: `deb` = 0, `deb_q` = 0, counter = 0;
  - synchronizers = 0;
  - `up_down` = 1.
- Reset values of outputs: `enable` = 0, `up_down` = 1, `run_led` = 0.

## Timing
- Button latency: let E0 be the first rising edge that samples the raw button high.
  - `deb` is high after edge E(`DEB_CYCLES`+1), given the input is held stable.
  - The FSM transitions at edge E(`DEB_CYCLES`+2).
  - With defaults, the STEP `enable` pulse is high for the single cycle following E6.
- Bounce rejection: any input glitch shorter than `DEB_CYCLES` synchronized cycles leaves `deb` unchanged.
- RUN:
  - The first `enable` is high in the `PRESC`-th cycle spent in RUN; subsequent pulses follow every `PRESC` cycles.
  - Leaving RUN deasserts `enable` in the very next cycle, even if the prescaler was at `PRESC`−1.
- `enable` is never high for two consecutive cycles in any mode.

## Structure
- Shared package `fsm_ctrl_pkg` holds:
  - state encoding localparams `ST_STOP`=2'd0, `ST_RUN`=2'd1, `ST_STEP`=2'd2;
  - the width function for counters, clog2 of the parameter.
- Sub-module `btn_debounce`, instantiated three times:
  - parameter `DEB_CYCLES`;
  - ports `clk`, `rst`, `raw`, `level`, `press`;
  - contains the synchronizer, debouncer and edge detector.
- The top level contains the mode FSM, the prescaler and the `up_down` register.

## Test plan
All scenarios use the defaults `DEB_CYCLES`=4, `PRESC`=5, with a 20 ns clock.
1. Reset: `rst`=1 for 2 cycles with all buttons low → `enable`=0, `up_down`=1, `run_led`=0. Then assert `rst` mid-RUN → STOP at the next edge, `enable`=0, `up_down`=1.
2. Single step: from STOP, hold `btn_step` high for 10 cycles, then low → exactly one `enable` pulse, in the cycle after E6. No further pulse while held. `run_led` stays 0.
3. Bounce: toggle `btn_run` every cycle for 8 cycles, then low → no press detected; `run_led` stays 0 and `enable` stays 0.
4. Run/stop:
   - Press `btn_run` → `run_led`=1 after E6; `enable` pulses in RUN cycles 5, 10, 15.
   - Press `btn_step` while in RUN → no extra pulse.
   - Press `btn_run` again → `run_led`=0 and no further `enable`.
5. Direction: two separate `btn_dir` presses → `up_down` goes 1→0 after the first press and 0→1 after the second. `enable` is unaffected.
6. Simultaneous: `btn_run` and `btn_step` rise on the same cycle from STOP → RUN is entered, no STEP pulse occurs, and the first `enable` arrives 5 cycles after entering RUN.

Source files
------------

// File: rtl/fsm_step_ctrl_pkg.sv
// Shared definitions for the sequence-FSM front-end control stage:
// mode state encoding and the counter width helper.
package fsm_ctrl_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_STOP = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_STEP = 2'd2;

    // Width of a counter that runs 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fsm_step_ctrl_if.sv
// Button inputs and FSM drive outputs of the control stage, grouped as one bundle.
interface fsm_step_ctrl_if;

    logic btn_run;
    logic btn_step;
    logic btn_dir;
    logic enable;
    logic up_down;
    logic run_led;

    // Side that drives the buttons and observes the strobes.
    modport master (
        output btn_run, btn_step, btn_dir,
        input  enable, up_down, run_led
    );

    // The control stage itself.
    modport slave (
        input  btn_run, btn_step, btn_dir,
        output enable, up_down, run_led
    );

endinterface

// File: rtl/fsm_step_ctrl_btn_debounce.sv
// Conditions one raw push-button: two-flop synchronizer, stability-count
// debouncer and a one-cycle rising-edge press strobe.
module btn_debounce
    import fsm_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int             DW       = cnt_w(DEB_CYCLES);
    localparam logic [DW-1:0]  DEB_LAST = DW'(DEB_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          deb_q, deb_d;
    logic          deb_prev_q, deb_prev_d;
    logic [DW-1:0] cnt_q, cnt_d;

    // Next-state: shift the synchronizer, count disagreeing samples, accept a new level once stable.
    always_comb begin
        sync1_d    = raw;
        sync2_d    = sync1_q;
        deb_prev_d = deb_q;
        deb_d      = deb_q;
        cnt_d      = '0;
        if (sync2_q != deb_q) begin
            if (cnt_q == DEB_LAST) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State registers; reset clears the whole chain so no stale press survives.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_prev_d;
            cnt_q      <= cnt_d;
        end
    end

    assign level = deb_q;
    assign press = deb_q & ~deb_prev_q;

endmodule

// File: rtl/fsm_step_ctrl.sv
// Front-end control for the sequence FSM: debounced run/step/dir buttons drive
// a STOP/RUN/STEP mode FSM, a RUN-mode prescaler and the direction register.
module fsm_step_ctrl
    import fsm_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = 4,
    parameter int PRESC      = 5
) (
    input  logic           clk,
    input  logic           rst,
    fsm_step_ctrl_if.slave bus
);

    localparam int            PW         = cnt_w(PRESC);
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);

    logic          run_press, step_press, dir_press;
    logic [2:0]    btn_level_unused;

    state_t        state_q, state_d;
    logic [PW-1:0] cnt_q, cnt_d;
    logic          up_down_q, up_down_d;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_run (
        .clk   (clk),
        .rst   (rst),
        .raw   (bus.btn_run),
        .level (btn_level_unused[0]),
        .press (run_press)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
        .clk   (clk),
        .rst   (rst),
        .raw   (bus.btn_step),
        .level (btn_level_unused[1]),
        .press (step_press)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dir (
        .clk   (clk),
        .rst   (rst),
        .raw   (bus.btn_dir),
        .level (btn_level_unused[2]),
        .press (dir_press)
    );

    // State register together with the prescaler and direction flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_STOP;
            cnt_q     <= '0;
            up_down_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            up_down_q <= up_down_d;
        end
    end

    // Next-state: mode transitions (run beats step in STOP), prescaler counts only while staying in RUN.
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        up_down_d = dir_press ? ~up_down_q : up_down_q;
        case (state_q)
            ST_STOP: begin
                if (run_press) begin
                    state_d = ST_RUN;
                end else if (step_press) begin
                    state_d = ST_STEP;
                end
            end
            ST_RUN: begin
                if (run_press) begin
                    state_d = ST_STOP;
                end
            end
            ST_STEP: begin
                state_d = ST_STOP;
            end
            default: begin
                state_d = ST_STOP;
            end
        endcase
        if ((state_q == ST_RUN) && (state_d == ST_RUN)) begin
            cnt_d = (cnt_q == PRESC_LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // Moore outputs decoded from the registered state and prescaler.
    always_comb begin
        bus.enable  = (state_q == ST_STEP) ||
                      ((state_q == ST_RUN) && (cnt_q == PRESC_LAST));
        bus.run_led = (state_q == ST_RUN);
        bus.up_down = up_down_q;
    end

endmodule
